// File: rtl/mips_dmem_resp.sv
// mips_dmem_resp: single-outstanding, fixed-latency data memory responder.
// A request is accepted in IDLE, waits LATENCY cycles, executes its load or
// byte-enabled store, then holds the response until the initiator takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_be        request payload, captured at the accept edge
//   rsp_valid / rsp_ready    response handshake (valid only in RESP)
//   rsp_rdata, rsp_err       load data (0 for stores/errors), reject flag
`timescale 1ns/1ps

module mips_dmem_resp #(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int unsigned WORD_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W       = 4;
  localparam logic [31:0]      LAST_WORD_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [CNT_W-1:0] CNT_LOAD       = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;

  // Word-organised store; never reset, contents undefined until written.
  logic [31:0] mem_q [DEPTH_WORDS];

  logic               addr_err_c;
  logic               commit_c;
  logic [WORD_AW-1:0] word_idx_c;
  logic [31:0]        rsp_rdata_d;

  // Full 32-bit range compare so high addresses never alias into the store.
  assign addr_err_c  = (addr_q[1:0] != 2'b00) || (addr_q > LAST_WORD_ADDR);
  assign commit_c    = (state_q == ST_WAIT) && (cnt_q == '0);
  assign word_idx_c  = addr_q[WORD_AW+1:2];
  assign rsp_rdata_d = (!we_q && !addr_err_c) ? mem_q[word_idx_c] : 32'h0;

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= addr_err_c;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // Returning to IDLE here (not accepting) enforces the idle gap
          // between a response handshake and the next accept.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled store write; commit_c is false while reset holds state IDLE,
  // so a reset during WAIT drops the pending store.
  always_ff @(posedge clk) begin
    if (commit_c && we_q && !addr_err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) begin
          mem_q[word_idx_c][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mips_dmem_resp.sv
// Self-checking bench for mips_dmem_resp: a LATENCY=2 instance exercised by a
// vector table, reset corner cases and random traffic against a byte-array
// model, plus a LATENCY=1 instance streaming back-to-back requests.
`timescale 1ns/1ps

module tb_mips_dmem_resp;

  localparam int unsigned TB_DEPTH = 128;
  localparam int          TB_LAT   = 2;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain byte array with a written-flag per byte.
  logic [7:0] mem_m [TB_DEPTH];
  bit         kn_m  [TB_DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [12];
  vec_t bvec [7];

  mips_dmem_resp #(.DEPTH_BYTES(TB_DEPTH), .LATENCY(TB_LAT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mips_dmem_resp #(.DEPTH_BYTES(TB_DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Applies one request to the byte model; returns expected data/err and a
  // mask of load bytes that have a defined value.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] exp_rd,
                       output logic exp_er, output logic [31:0] mask);
    exp_er = (addr % 4 != 0) || (addr > 32'(TB_DEPTH - 4));
    exp_rd = 32'h0;
    mask   = 32'hFFFF_FFFF;
    if (!exp_er) begin
      for (int k = 0; k < 4; k++) begin
        if (we) begin
          if (be[k]) begin
            mem_m[int'(addr) + k] = wdata[8*k +: 8];
            kn_m[int'(addr) + k]  = 1'b1;
          end
        end else begin
          exp_rd[8*k +: 8] = mem_m[int'(addr) + k];
          if (!kn_m[int'(addr) + k]) mask[8*k +: 8] = 8'h00;
        end
      end
    end
  endtask

  // Full transaction on the LATENCY=2 instance, entered and left at a negedge.
  // Junk is driven on the request inputs while busy, including a valid request
  // in the handshake cycle, which must not be accepted.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    chk("req_ready_in_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(TB_LAT));
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_addr = $urandom;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, rd);
      chk("hold_rsp_err", 32'(rsp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_no_accept", 32'(req_ready), 32'd1);
  endtask

  task automatic model_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int hold);
    logic [31:0] exp_rd, mask, rd;
    logic        exp_er, er;
    model(we, addr, wdata, be, exp_rd, exp_er, mask);
    txn(we, addr, wdata, be, hold, rd, er);
    chk({name, "_rdata"}, rd & mask, exp_rd & mask);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
  endtask

  initial begin
    logic [31:0] rd, exp_rd, mask, a;
    logic        er, exp_er;
    int          n;
    int          bi, bj, cyc, pres_cyc [7];

    for (int i = 0; i < int'(TB_DEPTH); i++) kn_m[i] = 1'b0;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'b0101, 0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 0, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,       32'h0,        4'b0000, 1, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h7C,       32'h01020304, 4'b1111, 0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h80,       32'hFFFFFFFF, 4'b1111, 0, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h7C,       32'h0,        4'b0000, 0, 32'h01020304, 1'b0};
    vecs[8]  = '{1'b1, 32'h10,       32'hAAAAAAAA, 4'b0000, 0, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 0, 32'hDE22BE44, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'b0000, 0, 32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'h10,       32'h0,        4'b0000, 5, 32'hDE22BE44, 1'b0};

    bvec[0] = '{1'b1, 32'h00, 32'hA5A5A5A5, 4'b1111, 0, 32'h0,        1'b0};
    bvec[1] = '{1'b1, 32'h04, 32'h12345678, 4'b1111, 0, 32'h0,        1'b0};
    bvec[2] = '{1'b0, 32'h00, 32'h0,        4'b0000, 0, 32'hA5A5A5A5, 1'b0};
    bvec[3] = '{1'b0, 32'h04, 32'h0,        4'b0000, 0, 32'h12345678, 1'b0};
    bvec[4] = '{1'b1, 32'h00, 32'h0000FFFF, 4'b0011, 0, 32'h0,        1'b0};
    bvec[5] = '{1'b0, 32'h00, 32'h0,        4'b0000, 0, 32'hA5A5FFFF, 1'b0};
    bvec[6] = '{1'b0, 32'h80, 32'h0,        4'b0000, 0, 32'h0,        1'b1};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1'b1;

    // Reset state of both instances.
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("b_rst_req_ready", 32'(b_req_ready), 32'd1);
    chk("b_rst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp_rd, exp_er, mask);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_er));
    end

    // Reset while a store waits in WAIT must drop the store.
    model_txn("cafe_store", 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 0, rd, er);
    chk("rst_wait_load_rdata", rd, 32'hCAFEF00D);
    chk("rst_wait_load_err", 32'(er), 32'd0);

    // Reset while holding a response drops it; no handshake follows.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h7C; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_resp_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'h0);
    chk("rst_resp_err", 32'(rsp_err), 32'd0);
    chk("rst_resp_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_after_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_after_ready", 32'(req_ready), 32'd1);

    // Random traffic against the byte model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
        2: a = 32'h80 + 32'($urandom_range(0, 3)) * 4;
        default: a = 32'($urandom_range(0, 31)) * 4;
      endcase
      model_txn("rand", 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // LATENCY=1 instance: request valid held high, response always taken.
    // Presented at negedge c, accepted next edge, response visible at c+2,
    // next accept presented at c+3.
    bi = 0; bj = 0; cyc = 0;
    while ((bi < 7 || bj < 7) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (b_rsp_valid && bj < 7) begin
        chk($sformatf("b%0d_rdata", bj), b_rsp_rdata, bvec[bj].exp_rd);
        chk($sformatf("b%0d_err", bj), 32'(b_rsp_err), 32'(bvec[bj].exp_er));
        chk($sformatf("b%0d_latency", bj), 32'(cyc - pres_cyc[bj]), 32'd2);
        bj++;
      end
      if (b_req_ready && bi < 7) begin
        b_req_valid = 1'b1; b_req_we = bvec[bi].we; b_req_addr = bvec[bi].addr;
        b_req_wdata = bvec[bi].wdata; b_req_be = bvec[bi].be;
        pres_cyc[bi] = cyc;
        if (bi > 0) chk($sformatf("b%0d_spacing", bi), 32'(cyc - pres_cyc[bi-1]), 32'd3);
        bi++;
      end
    end
    b_req_valid = 1'b0;
    chk("b_all_responses", 32'(bj), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_dmem_resp.md
MIPS_DMEM_RESP -- requirements
Module: mips_dmem_resp

Interface
REQ-001 Parameter DEPTH_BYTES, 128: size of the byte-addressable data store in bytes; SHALL be a multiple of 4.
REQ-002 Parameter LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i]; ignored on loads.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator takes the response.
REQ-013 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was rejected (misaligned or out of range).

Function
REQ-015 States SHALL be IDLE, WAIT and RESP; req_ready=1 only in IDLE, and rsp_valid=1 only in RESP.
REQ-016 Acceptance SHALL occur on a rising edge with req_valid=1 in IDLE; req_we, req_addr, req_wdata and req_be SHALL be captured at that edge; the state SHALL go to WAIT and a latency counter SHALL load LATENCY-1.
REQ-017 In WAIT the counter SHALL decrement by 1 per cycle; at the edge where counter=0 the access SHALL execute and the state SHALL go to RESP, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 Byte order SHALL be little-endian: byte at addr+k maps to bits [8k+7:8k], k=0..3.
REQ-019 A load SHALL return all 4 bytes, registered in rsp_rdata at the WAIT->RESP edge.
REQ-020 A store SHALL write only the bytes whose req_be bit is 1, at the WAIT->RESP edge; be=0000 SHALL complete with rsp_err=0 and no change to the store.
REQ-021 Error condition: addr[1:0]!=0 or addr > DEPTH_BYTES-4 (full 32-bit compare, no wrap). On error there SHALL be no store write, rsp_err=1 and rsp_rdata=0.
REQ-022 rsp_valid, rsp_rdata and rsp_err SHALL hold stable in RESP until rsp_ready=1; that edge SHALL return the state to IDLE.
REQ-023 No request SHALL be accepted in the cycle its predecessor's response handshakes; at most one request is outstanding, and the minimum request spacing is LATENCY+2 cycles.
REQ-024 A load after a store to the same address SHALL return the stored data; there is no forwarding hazard because requests are serialized.
REQ-025 Inputs other than rsp_ready SHALL be ignored outside IDLE.

Reset
REQ-026 While rst=1 the state SHALL be IDLE, the counter 0, and req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-027 Storage contents SHALL NOT be reset; contents after power-up are undefined until written.
REQ-028 A reset asserted in WAIT SHALL abort the request; an uncommitted store SHALL leave the store unchanged.
REQ-029 A reset asserted in RESP SHALL drop the response with no further handshake.

Verification
REQ-030 Store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after each accept.
REQ-031 With 0x10 holding 0xDEADBEEF, store wdata=0x11223344, be=0101, then load 0x10 -> 0xDE22BE44.
REQ-032 Load addr=0x13 -> rsp_err=1, rdata=0. Store addr=0x7C is accepted with err=0. Store addr=0x80 -> err=1 and memory unchanged.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0; the next accept occurs no earlier than the cycle after the rsp handshake.
REQ-034 Store 0x20 = 0xCAFEF00D, then assert rst one cycle after a second store to 0x20 (0x0) is accepted, then load 0x20 -> 0xCAFEF00D.
REQ-035 LATENCY=1 build: back-to-back requests with rsp_ready tied to 1 -> one accept every 3 cycles, with correct data.
